// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard frame receiver: strips E0/F0 prefixes and emits make codes as 1-cycle pulses.
// Optional odd-parity enforcement via `define PS2_PARITY_CHECK_EN; 4-cycle latency from pin fall on the stop bit.
module ps2_keyboard_decoder #(
  parameter int TIMEOUT_CYC = 85000,
  parameter int TO_W        = 17
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] ps2_data_o,
  output logic       ps2_valid_o,
  output logic       ps2_ext_o,
  output logic       ps2_err_o
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      clk_sync, dat_sync;
  logic            clk_prev;
  logic            fe, dat;

  state_t          state, state_nx;
  logic [2:0]      bitcnt, bitcnt_nx;
  logic [7:0]      shift, shift_nx;
  logic            par_bit, par_nx;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic            byte_rdy, rdy_nx;
  logic            frame_err, ferr_nx;
  logic            parity_ok, timeout;
  logic            ext_f, brk_f;

  // Bus idles high, so presetting the synchronizers to 1 avoids a false edge out of reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
      clk_prev <= clk_sync[1];
    end
  end

  assign fe  = clk_prev & ~clk_sync[1];
  assign dat = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  assign timeout = (state != IDLE) && !fe && (to_cnt == TO_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      bitcnt    <= bitcnt_nx;
      shift     <= shift_nx;
      par_bit   <= par_nx;
      to_cnt    <= to_nx;
      byte_rdy  <= rdy_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    shift_nx  = shift;
    par_nx    = par_bit;
    rdy_nx    = 1'b0;
    ferr_nx   = 1'b0;
    to_nx     = (state == IDLE || fe) ? '0 : to_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (fe && !dat) begin
          state_nx  = DATA;
          bitcnt_nx = '0;
        end
      end
      DATA: begin
        if (fe) begin
          shift_nx  = {dat, shift[7:1]};
          bitcnt_nx = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (fe) begin
          par_nx   = dat;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          state_nx = IDLE;
          if (dat && parity_ok) rdy_nx  = 1'b1;
          else                  ferr_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A falling edge in the timeout cycle takes precedence (timeout already excludes fe).
    if (timeout) begin
      state_nx = IDLE;
      ferr_nx  = 1'b1;
      to_nx    = '0;
    end
  end

  // Decode: the shift register still holds the byte in the cycle after byte_rdy.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ps2_data_o  <= 8'h00;
      ps2_valid_o <= 1'b0;
      ps2_ext_o   <= 1'b0;
      ps2_err_o   <= 1'b0;
      ext_f       <= 1'b0;
      brk_f       <= 1'b0;
    end else begin
      ps2_data_o  <= 8'h00;
      ps2_valid_o <= 1'b0;
      ps2_ext_o   <= 1'b0;
      ps2_err_o   <= frame_err;
      if (frame_err) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (byte_rdy) begin
        case (shift)
          8'h00: begin
            ps2_err_o <= 1'b1;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
          end
          8'hE0: ext_f <= 1'b1;
          8'hF0: brk_f <= 1'b1;
          default: begin
            if (brk_f) begin
              ext_f <= 1'b0;
              brk_f <= 1'b0;
            end else begin
              ps2_data_o  <= shift;
              ps2_valid_o <= 1'b1;
              ps2_ext_o   <= ext_f;
              ext_f       <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule
